// File: rtl/read_unit.sv
// Read-cycle engine for the ONFI NAND controller: strobes RE# with programmable
// low/high widths and captures one DQ word per strobe into a valid/ready register.
module read_unit #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16,
   parameter int T_RP   = 4,
   parameter int T_REH  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              activate,
   input  logic [CNT_W-1:0]  count,
   input  logic [DATA_W-1:0] nand_data_in,
   output logic              read_enable,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              out_ready
);

   localparam int T_MAX = (T_RP > T_REH) ? T_RP : T_REH;
   localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(T_RP - 1);
   localparam logic [TMR_W-1:0] REH_LOAD = TMR_W'(T_REH - 1);

   typedef enum logic [1:0] {IDLE, RE_LOW, RE_HIGH, STALL} state_t;

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] remaining;
   logic             stall;
   logic             capture;

   // A pending unaccepted word blocks the next strobe so it is never overwritten
   assign stall   = data_valid & ~out_ready;
   assign capture = (state == RE_LOW) && (timer == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         read_enable <= 1'b1;
         busy        <= 1'b0;
         data_valid  <= 1'b0;
         data_out    <= '0;
         timer       <= '0;
         remaining   <= '0;
      end else begin
         if (capture) begin
            data_out   <= nand_data_in;
            data_valid <= 1'b1;
         end else if (data_valid && out_ready) begin
            data_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (activate && (count != '0)) begin
                  remaining <= count;
                  busy      <= 1'b1;
                  if (stall) begin
                     state <= STALL;
                  end else begin
                     state       <= RE_LOW;
                     read_enable <= 1'b0;
                     timer       <= RP_LOAD;
                  end
               end
            end
            RE_LOW: begin
               if (timer == '0) begin
                  if (remaining != '0) remaining <= remaining - CNT_W'(1);
                  read_enable <= 1'b1;
                  timer       <= REH_LOAD;
                  state       <= RE_HIGH;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            RE_HIGH: begin
               if (timer == '0) begin
                  if (remaining == '0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else if (stall) begin
                     state <= STALL;
                  end else begin
                     state       <= RE_LOW;
                     read_enable <= 1'b0;
                     timer       <= RP_LOAD;
                  end
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            STALL: begin
               if (!stall) begin
                  state       <= RE_LOW;
                  read_enable <= 1'b0;
                  timer       <= RP_LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
